// File: rtl/picosoc_iomem_arb_pkg.sv
// Shared types and constants for the PicoSoC iomem round-robin arbiter.
package picosoc_iomem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_t;

   // Read data returned to a master whose access was aborted by the WAIT timeout.
   localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/picosoc_iomem_arbiter_pick.sv
// rr_priority_pick: combinational round-robin selector. Returns the first set request
// bit at or after ptr, wrapping modulo N (N need not be a power of two).
module rr_priority_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 any,
   output logic [$clog2(N)-1:0] idx
);

   localparam int PW = $clog2(N);
   localparam logic [PW:0] N_W = (PW + 1)'(N);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [PW-1:0]  off;
   logic [PW:0]    sum;

   // Rotating by ptr turns the wrap-around search into a plain lowest-set-bit search.
   assign req_dbl = {req, req} >> ptr;
   assign req_rot = req_dbl[N-1:0];

   // NOTE: off gets a default before the loop so every path assigns it and no latch is inferred.
   always_comb begin
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) off = PW'(i);
      end
   end

   assign any = |req;
   assign sum = {1'b0, ptr} + {1'b0, off};
   assign idx = (sum >= N_W) ? PW'(sum - N_W) : sum[PW-1:0];

endmodule

// File: rtl/picosoc_iomem_arbiter.sv
// picosoc_iomem_arbiter: round-robin share of one PicoSoC iomem slave among NUM_REQ masters.
// Define IOMEM_ARB_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES WAIT cycles without ready.
module picosoc_iomem_arbiter
   import picosoc_iomem_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*4-1:0]       req_wstrb,
   input  logic [NUM_REQ*32-1:0]      req_addr,
   input  logic [NUM_REQ*32-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [31:0]                req_rdata,
   output logic                       iomem_valid,
   output logic [3:0]                 iomem_wstrb,
   output logic [31:0]                iomem_addr,
   output logic [31:0]                iomem_wdata,
   input  logic                       iomem_ready,
   input  logic [31:0]                iomem_rdata,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       timeout_err
);

   localparam int GW = $clog2(NUM_REQ);
   localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

   arb_state_t           state_q, state_d;
   logic [GW-1:0]        rr_ptr_q, rr_ptr_d, grant_d;
   logic                 pick_any;
   logic [GW-1:0]        pick_idx;
   logic                 ready_hit, timeout_hit, finish;
   logic                 valid_d, terr_d;
   logic [3:0]           wstrb_d;
   logic [31:0]          addr_d, wdata_d, rdata_d;
   logic [NUM_REQ-1:0]   ready_d;

   rr_priority_pick #(.N(NUM_REQ)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign ready_hit = (state_q == ARB_WAIT) && iomem_ready;
   assign finish    = ready_hit || timeout_hit;

`ifdef IOMEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt;

   // wait_cnt counts completed WAIT cycles, so the abort lands on the TIMEOUT_CYCLES-th one.
   assign timeout_hit = (state_q == ARB_WAIT) && !iomem_ready && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset || state_q != ARB_WAIT) wait_cnt <= '0;
      else                              wait_cnt <= wait_cnt + 1'b1;
   end
`else
   // Without the timeout build WAIT holds until the slave answers.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // NOTE: every register here uses <= so each samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         grant_idx   <= '0;
         iomem_valid <= 1'b0;
         iomem_wstrb <= '0;
         iomem_addr  <= '0;
         iomem_wdata <= '0;
         req_ready   <= '0;
         req_rdata   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_idx   <= grant_d;
         iomem_valid <= valid_d;
         iomem_wstrb <= wstrb_d;
         iomem_addr  <= addr_d;
         iomem_wdata <= wdata_d;
         req_ready   <= ready_d;
         req_rdata   <= rdata_d;
         timeout_err <= terr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (pick_any) state_d = ARB_WAIT;
         ARB_WAIT: if (finish)   state_d = ARB_RESP;
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // Next values for the registered outputs; the request pulse and read data default to idle.
   always_comb begin
      valid_d  = iomem_valid;
      wstrb_d  = iomem_wstrb;
      addr_d   = iomem_addr;
      wdata_d  = iomem_wdata;
      grant_d  = grant_idx;
      rr_ptr_d = rr_ptr_q;
      ready_d  = '0;
      rdata_d  = '0;
      terr_d   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               valid_d = 1'b1;
               wstrb_d = req_wstrb[pick_idx*4 +: 4];
               addr_d  = req_addr[pick_idx*32 +: 32];
               wdata_d = req_wdata[pick_idx*32 +: 32];
               grant_d = pick_idx;
            end
         end
         ARB_WAIT: begin
            if (finish) begin
               valid_d            = 1'b0;
               ready_d[grant_idx] = 1'b1;
               rdata_d            = ready_hit ? iomem_rdata : TIMEOUT_RDATA;
               terr_d             = timeout_hit;
               rr_ptr_d           = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
